// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: shared types for the two-master SRAM bus arbiter
package sram_bus_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
  typedef struct packed {
    logic       req;
    logic       wr;
    logic [1:0] size;
    word_t      addr;
    word_t      wdata;
  } sram_req_t;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between fetch and data masters, data priority with starvation bound
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_t state, state_nxt;
  arb_owner_t owner, winner, sel;
  logic [CW-1:0] starve_cnt;
  logic active, hs, done;
  sram_req_t i_r, d_r, b_r;
  always_comb begin
    i_r = '{req: i_req, wr: 1'b0, size: SIZE_WORD, addr: i_addr, wdata: 32'd0};
    d_r = '{req: d_req, wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
    winner = (d_req && !(i_req && starve_cnt == LIM)) ? OWN_D : OWN_I;
    sel = (state == IDLE) ? winner : owner;
    active = resetn && ((state == IDLE) ? (i_req || d_req) : (state == HOLD));
    b_r = active ? ((sel == OWN_D) ? d_r : i_r) : '0;
    hs = active && bus_addr_ok;
    done = resetn && bus_data_ok && (state == WAIT || hs);
    state_nxt = (state == WAIT) ? (bus_data_ok ? IDLE : WAIT) :
                !active         ? state :
                !bus_addr_ok    ? HOLD :
                bus_data_ok     ? IDLE : WAIT;
  end
  assign bus_req   = b_r.req;
  assign bus_wr    = b_r.wr;
  assign bus_size  = b_r.size;
  assign bus_addr  = b_r.addr;
  assign bus_wdata = b_r.wdata;
  assign i_addr_ok = hs && sel == OWN_I;
  assign d_addr_ok = hs && sel == OWN_D;
  assign i_data_ok = done && sel == OWN_I;
  assign d_data_ok = done && sel == OWN_D;
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_I;
    end else begin
      state <= state_nxt;
      if (state == IDLE && active) owner <= winner;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starve_cnt <= '0;
    else if (hs && sel == OWN_I) starve_cnt <= '0;
    else if (hs && i_req) starve_cnt <= (starve_cnt == LIM) ? starve_cnt : starve_cnt + CW'(1);
    else if (state == IDLE && !i_req) starve_cnt <= '0;
  end
  always @(posedge clk) begin
    if (resetn && state == HOLD) assert ((owner == OWN_D) ? d_req : i_req);
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed and randomized checks against a transaction-level arbiter model
module tb_sram_bus_arbiter;
  localparam int LIMIT = 4;
  logic clk = 0, resetn = 0;
  logic i_req = 0, d_req = 0, d_wr = 0, bus_addr_ok = 0, bus_data_ok = 0;
  logic [1:0] d_size = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, bus_rdata = 0;
  logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, bus_req, bus_wr;
  logic [1:0] bus_size;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic s_resetn = 0, s_i_req = 0, s_d_req = 0, s_d_wr = 0, s_aok = 0, s_dok = 0;
  logic [1:0] s_d_size = 0;
  logic [31:0] s_i_addr = 0, s_d_addr = 0, s_d_wdata = 0, s_rdata = 0;
  int tests = 0, fails = 0;
  int m_own = 0, m_starve = 0;
  bit m_acc = 0;
  bit e_req, e_i_aok, e_d_aok, e_i_dok, e_d_dok;
  sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic clr();
    s_resetn = 1; s_i_req = 0; s_d_req = 0; s_d_wr = 0; s_aok = 0; s_dok = 0;
    s_d_size = 0; s_i_addr = 0; s_d_addr = 0; s_d_wdata = 0; s_rdata = 0;
  endtask
  task automatic step();
    int g;
    bit hs, done;
    @(negedge clk);
    resetn = s_resetn; i_req = s_i_req; i_addr = s_i_addr; d_req = s_d_req; d_wr = s_d_wr;
    d_size = s_d_size; d_addr = s_d_addr; d_wdata = s_d_wdata;
    bus_addr_ok = s_aok; bus_data_ok = s_dok; bus_rdata = s_rdata;
    #2;
    g = 0; hs = 0; done = 0;
    if (!resetn) begin
      m_own = 0; m_acc = 0; m_starve = 0;
    end else begin
      g = m_own;
      if (m_own == 0 && (i_req || d_req)) g = (d_req && !(i_req && m_starve == LIMIT)) ? 2 : 1;
      hs = (g != 0) && !m_acc && bus_addr_ok;
      done = m_acc ? bus_data_ok : (hs && bus_data_ok);
      if (hs && g == 1) m_starve = 0;
      else if (hs && g == 2 && i_req) m_starve = (m_starve == LIMIT) ? LIMIT : m_starve + 1;
      else if (m_own == 0 && !i_req) m_starve = 0;
    end
    e_req = resetn && g != 0 && !m_acc;
    e_i_aok = hs && g == 1; e_d_aok = hs && g == 2;
    e_i_dok = done && g == 1; e_d_dok = done && g == 2;
    chk("bus_req", bus_req, e_req);
    chk("i_addr_ok", i_addr_ok, e_i_aok);
    chk("d_addr_ok", d_addr_ok, e_d_aok);
    chk("i_data_ok", i_data_ok, e_i_dok);
    chk("d_data_ok", d_data_ok, e_d_dok);
    if (e_req) begin
      chk("bus_wr", bus_wr, (g == 2) ? d_wr : 1'b0);
      chk("bus_size", bus_size, (g == 2) ? d_size : 2'd2);
      chk("bus_addr", bus_addr, (g == 2) ? d_addr : i_addr);
      chk("bus_wdata", bus_wdata, (g == 2) ? d_wdata : 32'd0);
    end else if (g == 0) begin
      chk("idle_bus_addr", bus_addr, 32'd0);
      chk("idle_bus_wdata", bus_wdata, 32'd0);
    end
    if (e_i_dok) chk("i_rdata", i_rdata, bus_rdata);
    if (e_d_dok) chk("d_rdata", d_rdata, bus_rdata);
    if (resetn) begin
      if (done) begin m_own = 0; m_acc = 0; end
      else if (e_req) begin m_own = g; m_acc = hs; end
    end
  endtask
  initial begin
    string so;
    bit i_hold, d_hold, sl_pend;
    int sl_cnt, lat;
    s_resetn = 0; step(); step();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_i_aok", i_addr_ok, 0);
    chk("rst_d_dok", d_data_ok, 0);
    clr(); step();
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00000; s_aok = 1; step();
    chk("read_bus_addr", bus_addr, 32'hBFC00000);
    chk("read_i_aok", i_addr_ok, 1);
    clr(); step();
    chk("read_wait_req", bus_req, 0);
    clr(); s_dok = 1; s_rdata = 32'h3C1DBFC0; step();
    chk("read_i_dok", i_data_ok, 1);
    chk("read_i_rdata", i_rdata, 32'h3C1DBFC0);
    chk("read_d_dok", d_data_ok, 0);
    clr(); step();
    chk("read_i_dok_pulse", i_data_ok, 0);
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00004; s_d_req = 1; s_d_wr = 1; s_d_size = 2;
    s_d_addr = 32'h80001000; s_d_wdata = 32'h12345678; s_aok = 1; step();
    chk("conf_bus_wr", bus_wr, 1);
    chk("conf_bus_wdata", bus_wdata, 32'h12345678);
    chk("conf_d_aok", d_addr_ok, 1);
    chk("conf_i_aok", i_addr_ok, 0);
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00004; s_dok = 1; step();
    chk("conf_d_dok", d_data_ok, 1);
    chk("conf_i_aok_wait", i_addr_ok, 0);
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00004; s_aok = 1; s_dok = 1; step();
    chk("conf_i_grant", i_addr_ok, 1);
    chk("conf_i_bus_wr", bus_wr, 0);
    chk("conf_i_bus_addr", bus_addr, 32'hBFC00004);
    for (int k = 0; k < 3; k++) begin
      clr(); s_i_req = 1; s_i_addr = 32'hBFC00100; s_d_req = (k >= 1); s_d_addr = 32'h80002000; step();
      chk("hold_bus_addr", bus_addr, 32'hBFC00100);
      chk("hold_d_aok", d_addr_ok, 0);
    end
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00100; s_d_req = 1; s_d_addr = 32'h80002000; s_aok = 1; s_dok = 1; step();
    chk("hold_i_aok", i_addr_ok, 1);
    chk("hold_d_aok_end", d_addr_ok, 0);
    clr(); s_d_req = 1; s_d_addr = 32'h80002000; s_aok = 1; s_dok = 1; step();
    chk("zl_d_aok", d_addr_ok, 1);
    chk("zl_d_dok", d_data_ok, 1);
    chk("zl_size", bus_size, 0);
    clr(); s_d_req = 1; s_d_addr = 32'h80002001; s_aok = 1; s_dok = 1; step();
    chk("zl_next_aok", d_addr_ok, 1);
    chk("zl_next_addr", bus_addr, 32'h80002001);
    clr(); step();
    so = "";
    for (int k = 0; k < 6; k++) begin
      clr(); s_i_req = 1; s_i_addr = 32'hBFC00200; s_d_req = 1; s_d_addr = 32'h80004000; s_aok = 1; s_dok = 1; step();
      if (d_addr_ok) so = {so, "D"};
      else if (i_addr_ok) so = {so, "I"};
      else so = {so, "-"};
    end
    tests++;
    if (so != "DDDDID") begin
      fails++;
      $display("FAIL starve_order: got %s want DDDDID", so);
    end
    clr(); s_d_req = 1; s_d_addr = 32'h80003000; s_aok = 1; step();
    clr(); s_resetn = 0; s_i_req = 1; step();
    chk("rst_mid_bus_req", bus_req, 0);
    chk("rst_mid_i_aok", i_addr_ok, 0);
    chk("rst_mid_d_dok", d_data_ok, 0);
    clr(); s_resetn = 0; step();
    clr(); s_i_req = 1; s_i_addr = 32'hBFC00300; s_aok = 1; s_dok = 1; step();
    chk("post_rst_i_aok", i_addr_ok, 1);
    chk("post_rst_i_dok", i_data_ok, 1);
    clr();
    i_hold = 0; d_hold = 0; sl_pend = 0; sl_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_hold && $urandom_range(0, 2) == 0) begin
        i_hold = 1; s_i_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!d_hold && $urandom_range(0, 2) == 0) begin
        d_hold = 1; s_d_wr = 1'($urandom_range(0, 1)); s_d_size = 2'($urandom_range(0, 2));
        s_d_addr = $urandom; s_d_wdata = $urandom;
      end
      s_i_req = i_hold; s_d_req = d_hold;
      lat = int'($urandom_range(0, 3));
      if (sl_pend) begin
        s_aok = 1'($urandom_range(0, 1)); s_dok = (sl_cnt == 0);
      end else begin
        s_aok = ($urandom_range(0, 2) != 0);
        s_dok = s_aok ? (lat == 0) : ($urandom_range(0, 3) == 0);
      end
      s_rdata = $urandom;
      step();
      if (e_i_aok) i_hold = 0;
      if (e_d_aok) d_hold = 0;
      if (sl_pend) begin
        if (sl_cnt == 0) sl_pend = 0;
        else sl_cnt--;
      end else if (e_req && s_aok && lat != 0) begin
        sl_pend = 1; sl_cnt = lat - 1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
